tcdm_tgt_responder: RTL and testbench



---
 rtl/tcdm_tgt_responder.sv | 166 ++++++++++++++++
 tb/tb_tcdm_tgt_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_tgt_responder.sv
// Crossbar target endpoint: issues routed requests to a fixed-latency SRAM bank and returns
// tagged responses in order. Define TCDM_TGT_RESPONDER_BYPASS_EN to let the pipeline tail drive the response port directly.
module tcdm_tgt_responder #(
  parameter  int NumIn         = 4,
  parameter  int AddrWidth     = 10,
  parameter  int DataWidth     = 32,
  parameter  int MemLatency    = 1,
  parameter  int RespFifoDepth = 2,
  localparam int IniW          = (NumIn > 1) ? $clog2(NumIn) : 1,
  localparam int BeW           = DataWidth / 8,
  localparam int ReqDataWidth  = 1 + BeW + AddrWidth + DataWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [IniW-1:0]         req_ini_addr_i,
  input  logic [ReqDataWidth-1:0] req_wdata_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [IniW-1:0]         resp_ini_addr_o,
  output logic [DataWidth-1:0]    resp_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddrWidth-1:0]    mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [BeW-1:0]          mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int OccW = $clog2(RespFifoDepth + 1);
  localparam int PtrW = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
  localparam logic [OccW-1:0] OccMax  = OccW'(RespFifoDepth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(RespFifoDepth - 1);

  logic [OccW-1:0] r_occ;
  logic            w_accept;
  logic            w_resp_fire;

  // In-flight pipeline: valid bits are reset, payload is not.
  logic [MemLatency-1:0]           r_sr_vld;
  logic [MemLatency-1:0]           r_sr_wen;
  logic [MemLatency-1:0][IniW-1:0] r_sr_ini;
  logic                            w_tail_vld;
  logic [IniW-1:0]                 w_tail_ini;
  logic [DataWidth-1:0]            w_tail_data;

  logic [IniW-1:0]      r_fifo_ini  [RespFifoDepth];
  logic [DataWidth-1:0] r_fifo_data [RespFifoDepth];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [OccW-1:0]      r_fcnt;
  logic                 w_fifo_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_byp;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Ready depends only on registered occupancy (and reset), never on req_valid_i.
  assign req_ready_o = !rst_i && (r_occ < OccMax);
  assign w_accept    = req_valid_i && req_ready_o;

  assign mem_req_o   = w_accept;
  assign mem_we_o    = req_wdata_i[ReqDataWidth-1];
  assign mem_be_o    = req_wdata_i[DataWidth+AddrWidth +: BeW];
  assign mem_addr_o  = req_wdata_i[DataWidth +: AddrWidth];
  assign mem_wdata_o = req_wdata_i[DataWidth-1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_resp_fire})
        2'b10:   r_occ <= r_occ + OccW'(1);
        2'b01:   r_occ <= r_occ - OccW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sr_vld <= '0;
    end else begin
      r_sr_vld[0] <= w_accept;
      for (int i = 1; i < MemLatency; i++) begin
        r_sr_vld[i] <= r_sr_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    r_sr_wen[0] <= mem_we_o;
    r_sr_ini[0] <= req_ini_addr_i;
    for (int i = 1; i < MemLatency; i++) begin
      r_sr_wen[i] <= r_sr_wen[i-1];
      r_sr_ini[i] <= r_sr_ini[i-1];
    end
  end

  assign w_tail_vld  = r_sr_vld[MemLatency-1];
  assign w_tail_ini  = r_sr_ini[MemLatency-1];
  assign w_tail_data = r_sr_wen[MemLatency-1] ? '0 : mem_rdata_i;

`ifdef TCDM_TGT_RESPONDER_BYPASS_EN
  assign w_byp = w_fifo_empty && w_tail_vld;
`else
  assign w_byp = 1'b0;
`endif

  assign w_fifo_empty = (r_fcnt == '0);
  assign w_push       = w_tail_vld && !(w_byp && resp_ready_i);
  assign w_pop        = !w_fifo_empty && resp_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + OccW'(1);
        2'b01:   r_fcnt <= r_fcnt - OccW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // NOTE: response storage is deliberately not reset; the output mux zeroes it whenever it is not valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_ini[r_wptr]  <= w_tail_ini;
      r_fifo_data[r_wptr] <= w_tail_data;
    end
  end

  assign resp_valid_o = !w_fifo_empty || w_byp;
  assign w_resp_fire  = resp_valid_o && resp_ready_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    resp_ini_addr_o = '0;
    resp_rdata_o    = '0;
    if (!w_fifo_empty) begin
      resp_ini_addr_o = r_fifo_ini[r_rptr];
      resp_rdata_o    = r_fifo_data[r_rptr];
    end else if (w_byp) begin
      resp_ini_addr_o = w_tail_ini;
      resp_rdata_o    = w_tail_data;
    end
  end

  // Slot reservation at accept time bounds occupancy and keeps the FIFO from overflowing.
  a_occ_max: assert property (@(posedge clk_i) disable iff (rst_i) r_occ <= OccMax);
  a_occ_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_resp_fire && !w_accept && (r_occ == '0)));
  a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && (r_fcnt == OccMax)));

endmodule

// File: tb/tb_tcdm_tgt_responder.sv
// Self-checking bench for tcdm_tgt_responder (MemLatency=2, RespFifoDepth=3, default build):
// directed vector table, hand-written multi-cycle sequences, and a scoreboarded random stream.
`timescale 1ns/1ps
module tb_tcdm_tgt_responder;
  localparam int NumIn = 4, AddrWidth = 10, DataWidth = 32, MemLatency = 2, RespFifoDepth = 3;
  localparam int IniW = 2, BeW = 4, ReqW = 1 + BeW + AddrWidth + DataWidth;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid_i, req_ready_o;
  logic [IniW-1:0] req_ini_addr_i;
  logic [ReqW-1:0] req_wdata_i;
  logic            resp_valid_o, resp_ready_i;
  logic [IniW-1:0] resp_ini_addr_o;
  logic [31:0]     resp_rdata_o;
  logic            mem_req_o, mem_we_o;
  logic [9:0]      mem_addr_o;
  logic [31:0]     mem_wdata_o, mem_rdata_i;
  logic [3:0]      mem_be_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tcdm_tgt_responder #(
    .NumIn(NumIn), .AddrWidth(AddrWidth), .DataWidth(DataWidth),
    .MemLatency(MemLatency), .RespFifoDepth(RespFifoDepth)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ini_addr_i(req_ini_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_ini_addr_o(resp_ini_addr_o), .resp_rdata_o(resp_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  // Two-cycle SRAM model with byte enables; noise_en scrambles the read bus.
  logic [31:0] mem_m [1024];
  logic [31:0] r_p0, r_p1;
  logic        noise_en = 1'b0;
  logic [31:0] noise_val = '0;
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem_m[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        r_p0 <= mem_m[mem_addr_o];
      end
    end
    r_p1 <= r_p0;
  end
  assign mem_rdata_i = noise_en ? noise_val : r_p1;

  function automatic logic [31:0] pat(input int i);
    return {16'(i) ^ 16'h5A5A, ~16'(i)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic rr, input logic [1:0] ini, input logic wen,
                       input logic [3:0] be, input logic [9:0] addr, input logic [31:0] wdata);
    req_valid_i    = vld;
    resp_ready_i   = rr;
    req_ini_addr_i = ini;
    req_wdata_i    = {wen, be, addr, wdata};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: order, tags, data, ready vs. modelled occupancy, stability under stall.
  typedef struct packed { logic [1:0] ini; logic [31:0] data; } rsp_t;
  rsp_t        sbq[$];
  logic        sb_en = 1'b0;
  int          occ_m = 0;
  logic        prev_stall = 1'b0;
  logic [1:0]  prev_ini;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (sb_en) begin
      rsp_t e;
      check("sb_ready", req_ready_o, occ_m < RespFifoDepth);
      if (prev_stall) begin
        check("hold_valid", resp_valid_o, 1);
        check("hold_ini", resp_ini_addr_o, prev_ini);
        check("hold_data", resp_rdata_o, prev_data);
      end
      if (req_valid_i && req_ready_o) begin
        e.ini  = req_ini_addr_i;
        e.data = req_wdata_i[ReqW-1] ? 32'h0 : mem_m[req_wdata_i[DataWidth +: AddrWidth]];
        sbq.push_back(e);
        occ_m++;
      end
      if (resp_valid_o && resp_ready_i) begin
        if (sbq.size() == 0) begin
          check("sb_spurious_resp", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("sb_ini", resp_ini_addr_o, e.ini);
          check("sb_data", resp_rdata_o, e.data);
        end
        occ_m--;
      end
      prev_stall = resp_valid_o && !resp_ready_i;
      prev_ini   = resp_ini_addr_o;
      prev_data  = resp_rdata_o;
    end
  end

  task automatic sb_start();
    sbq.delete();
    occ_m      = 0;
    prev_stall = 1'b0;
    sb_en      = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (n < 40 && (sbq.size() != 0 || occ_m != 0)) begin
      tick();
      drive(0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      n++;
    end
    check(name, sbq.size() + occ_m, 0);
  endtask

  typedef struct {
    logic vld; logic wen; logic [1:0] ini; logic [3:0] be; logic [9:0] addr; logic [31:0] wdata;
    logic e_rv; logic [1:0] e_ini; logic [31:0] e_rdata;
  } vec_t;
  vec_t vecs[20];

  function automatic vec_t mk(input logic vld, input logic wen, input logic [1:0] ini,
                              input logic [3:0] be, input logic [9:0] addr, input logic [31:0] wdata,
                              input logic e_rv, input logic [1:0] e_ini, input logic [31:0] e_rdata);
    vec_t v;
    v.vld = vld; v.wen = wen; v.ini = ini; v.be = be; v.addr = addr; v.wdata = wdata;
    v.e_rv = e_rv; v.e_ini = e_ini; v.e_rdata = e_rdata;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    vec_t v;
    for (int i = 0; i < 1024; i++) mem_m[i] = pat(i);
    mem_m[10'h10] = 32'hDEADBEEF;

    for (int k = 0; k < 20; k++) vecs[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 3, 4'hF, 10'h10, 32'h0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF);
    vecs[6]  = mk(1, 1, 2, 4'hF, 10'h5, 32'h12345678, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 2, 32'h0);
    vecs[10] = mk(1, 0, 1, 4'hF, 10'h5, 32'h0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h12345678);
    vecs[14] = mk(1, 1, 0, 4'h3, 10'h5, 32'hAAAABBBB, 0, 0, 0);
    vecs[15] = mk(1, 0, 1, 4'hF, 10'h5, 32'h0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234BBBB);

    // Power-on reset with a request offered: everything must stay quiet.
    rst = 1'b1;
    drive(1, 1, 2, 0, 4'hF, 10'h10, 0);
    #12;
    check("rst_ready", req_ready_o, 0);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_resp_ini", resp_ini_addr_o, 0);
    check("rst_resp_rdata", resp_rdata_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rel_ready", req_ready_o, 1);

    // Directed table: single read, write ack, write-then-read, partial byte enables.
    for (int k = 0; k < 20; k++) begin
      v = vecs[k];
      tick();
      drive(v.vld, 1, v.ini, v.wen, v.be, v.addr, v.wdata);
      @(negedge clk);
      check($sformatf("v%0d_ready", k), req_ready_o, 1);
      check($sformatf("v%0d_mem_req", k), mem_req_o, v.vld);
      if (v.vld) begin
        check($sformatf("v%0d_mem_we", k), mem_we_o, v.wen);
        check($sformatf("v%0d_mem_be", k), mem_be_o, v.be);
        check($sformatf("v%0d_mem_addr", k), mem_addr_o, v.addr);
        if (v.wen) check($sformatf("v%0d_mem_wdata", k), mem_wdata_o, v.wdata);
      end
      check($sformatf("v%0d_resp_valid", k), resp_valid_o, v.e_rv);
      if (v.e_rv) begin
        check($sformatf("v%0d_resp_ini", k), resp_ini_addr_o, v.e_ini);
        check($sformatf("v%0d_resp_rdata", k), resp_rdata_o, v.e_rdata);
      end
    end

    // Backpressure: five offers with resp_ready low, only three fit.
    tick();
    sb_start();
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      drive(1, 0, 2'(k), 0, 4'hF, 10'(32 + k), 0);
      @(negedge clk);
      check($sformatf("bp_ready%0d", k), req_ready_o, k < 3);
      if (req_ready_o) acc++;
    end
    check("bp_accepts", acc, 3);
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("bp_drain_ready%0d", k), req_ready_o, k > 0);
      check($sformatf("bp_drain_valid%0d", k), resp_valid_o, k < 3);
      if (k < 3) begin
        check($sformatf("bp_drain_ini%0d", k), resp_ini_addr_o, k);
        check($sformatf("bp_drain_data%0d", k), resp_rdata_o, pat(32 + k));
      end
    end

    // Accept and pop in the same cycle at occ=2 must leave occupancy at 2.
    tick(); drive(1, 0, 1, 0, 4'hF, 10'h30, 0);
    tick(); drive(1, 0, 2, 0, 4'hF, 10'h31, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0);
    tick(); drive(1, 1, 3, 0, 4'hF, 10'h32, 0);
    @(negedge clk);
    check("sim_ready_occ2", req_ready_o, 1);
    check("sim_valid", resp_valid_o, 1);
    check("sim_ini", resp_ini_addr_o, 1);
    tick(); drive(1, 0, 0, 0, 4'hF, 10'h33, 0);
    @(negedge clk);
    check("sim_ready_after", req_ready_o, 1);
    tick(); drive(1, 0, 1, 0, 4'hF, 10'h34, 0);
    @(negedge clk);
    check("sim_ready_full", req_ready_o, 0);
    drain("sim_drain");

    // Random stream against the scoreboard.
    for (int c = 0; c < 1000; c++) begin
      tick();
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, 2'($urandom), 1'($urandom),
            4'($urandom), 10'($urandom_range(0, 63)), $urandom);
    end
    drain("rnd_drain");

    // Reset pulse with one response pending and one read in flight.
    tick();
    sb_en = 1'b0;
    drive(1, 0, 1, 0, 4'hF, 10'h40, 0);
    tick(); drive(1, 0, 2, 0, 4'hF, 10'h41, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0);
    tick(); drive(1, 0, 3, 0, 4'hF, 10'h42, 0);
    #1;
    check("mid_pre_valid", resp_valid_o, 1);
    check("mid_pre_rdata", resp_rdata_o, pat(32'h40));
    rst = 1'b1;
    #1;
    check("mid_rst_ready", req_ready_o, 0);
    check("mid_rst_valid", resp_valid_o, 0);
    check("mid_rst_mem_req", mem_req_o, 0);
    check("mid_rst_ini", resp_ini_addr_o, 0);
    check("mid_rst_rdata", resp_rdata_o, 0);
    tick();
    rst = 1'b0;
    noise_en = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      noise_val = $urandom;
      @(negedge clk);
      if (k == 0) check("mid_rel_ready", req_ready_o, 1);
      check($sformatf("mid_rel_no_resp%0d", k), resp_valid_o, 0);
    end
    noise_en = 1'b0;

    // Short random run to show normal operation resumes after reset.
    tick();
    sb_start();
    for (int c = 0; c < 40; c++) begin
      tick();
      drive(($urandom % 2) != 0, ($urandom % 2) != 0, 2'($urandom), 1'($urandom),
            4'($urandom), 10'($urandom_range(0, 63)), $urandom);
    end
    drain("post_rst_drain");
    sb_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
